// File: rtl/ecc4_pkg.sv
// ecc4_pkg: shared types and SECDED helpers for the 4-bit ECC word store.
//   codeword_t    : {p, c[2:0], d[3:0]} packed 8-bit codeword
//   scrub_state_t : scrubber FSM states
//   dec_result_t  : decoder result {data, correctable, uncorrectable}
//   ecc4_encode   : data -> codeword
//   ecc4_decode   : codeword -> corrected data plus error classification
package ecc4_pkg;

  localparam int CW_W = 8;

  typedef struct packed {
    logic       p;
    logic [2:0] c;
    logic [3:0] d;
  } codeword_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCRUB_RD = 2'd1,
    SCRUB_WB = 2'd2
  } scrub_state_t;

  typedef struct packed {
    logic [3:0] data;
    logic       correctable;
    logic       uncorrectable;
  } dec_result_t;

  function automatic codeword_t ecc4_encode(input logic [3:0] d);
    codeword_t cw;
    cw.d    = d;
    cw.c[0] = d[3] ^ d[2] ^ d[0];
    cw.c[1] = d[3] ^ d[1] ^ d[0];
    cw.c[2] = d[2] ^ d[1] ^ d[0];
    cw.p    = ^{cw.c, cw.d};
    return cw;
  endfunction

  // Single-bit errors anywhere (data, check or parity) are correctable; any
  // nonzero syndrome with even overall parity is a double error.
  function automatic dec_result_t ecc4_decode(input codeword_t cw);
    logic [2:0]  s;
    logic        q;
    dec_result_t r;
    s[0] = cw.d[3] ^ cw.d[2] ^ cw.d[0] ^ cw.c[0];
    s[1] = cw.d[3] ^ cw.d[1] ^ cw.d[0] ^ cw.c[1];
    s[2] = cw.d[2] ^ cw.d[1] ^ cw.d[0] ^ cw.c[2];
    q    = ^cw;
    r.data          = cw.d;
    r.correctable   = 1'b0;
    r.uncorrectable = 1'b0;
    if (s != 3'd0 && !q) begin
      r.uncorrectable = 1'b1;
    end else if (q) begin
      r.correctable = 1'b1;
      case (s)
        3'd3:    r.data[3] = ~cw.d[3];
        3'd5:    r.data[2] = ~cw.d[2];
        3'd6:    r.data[1] = ~cw.d[1];
        3'd7:    r.data[0] = ~cw.d[0];
        default: r.data = cw.d;  // check-bit or parity-bit error, data intact
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ecc4_decoder.sv
// ecc4_decoder: combinational SECDED decoder for one 8-bit codeword.
//   cw_i            : stored codeword {p, c[2:0], d[3:0]}
//   data_o          : corrected data (raw data when uncorrectable)
//   correctable_o   : single-bit error present (data, check or parity bit)
//   uncorrectable_o : double-bit error detected
module ecc4_decoder
  import ecc4_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output logic [3:0]      data_o,
  output logic            correctable_o,
  output logic            uncorrectable_o
);

  dec_result_t res;

  assign res             = ecc4_decode(codeword_t'(cw_i));
  assign data_o          = res.data;
  assign correctable_o   = res.correctable;
  assign uncorrectable_o = res.uncorrectable;

endmodule

// File: rtl/ecc_scrubber_4.sv
// ecc_scrubber_4: SECDED-protected 4-bit word store with background scrubber.
//   clock, reset (sync, active-low)
//   req_valid/req_we/req_addr/req_wdata/req_ready : host request port
//   rsp_valid/rsp_rdata/rsp_err                    : registered read response
//   scrub_en                                       : enables background scrub
//   inj_valid/inj_addr/inj_mask                    : fault injection (XOR)
//   scrub_busy, pass_done                          : scrubber status
//   corr_count, uncorr_count, last_err_addr        : error statistics
module ecc_scrubber_4
  import ecc4_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int SCRUB_INTERVAL = 8,
  parameter int CNT_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [3:0]        rsp_rdata,
  output logic              rsp_err,
  input  logic              scrub_en,
  input  logic              inj_valid,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [CW_W-1:0]   inj_mask,
  output logic              scrub_busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count,
  output logic [ADDR_W-1:0] last_err_addr
);

  localparam int TMR_W = $clog2(SCRUB_INTERVAL + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [CW_W-1:0]   mem_q [DEPTH];
  logic [CW_W-1:0]   mem_d [DEPTH];
  scrub_state_t      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CW_W-1:0]   wb_cw_q, wb_cw_d;
  logic              rsp_valid_q, rsp_err_q, pass_done_q;
  logic [3:0]        rsp_rdata_q;
  logic [CNT_W-1:0]  corr_count_q, uncorr_count_q;
  logic [ADDR_W-1:0] last_err_addr_q;

  logic [3:0] host_data, scrub_data;
  logic       host_corr_unused, host_uncorr_raw;
  logic       scrub_corr_raw, scrub_uncorr_raw;

  logic accept, host_wr, host_rd, host_uncorr;
  logic scrub_uncorr, scrub_fixed, wb_write, ptr_adv;

  ecc4_decoder u_host_dec (
    .cw_i            (mem_q[req_addr]),
    .data_o          (host_data),
    .correctable_o   (host_corr_unused),
    .uncorrectable_o (host_uncorr_raw)
  );

  ecc4_decoder u_scrub_dec (
    .cw_i            (mem_q[ptr_q]),
    .data_o          (scrub_data),
    .correctable_o   (scrub_corr_raw),
    .uncorrectable_o (scrub_uncorr_raw)
  );

  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign host_wr     = accept && req_we;
  assign host_rd     = accept && !req_we;
  assign host_uncorr = host_rd && host_uncorr_raw;

  // Scrubber FSM next state. The host port is only open in IDLE, so host and
  // scrub events can never land in the same cycle.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    wb_cw_d      = wb_cw_q;
    scrub_uncorr = 1'b0;
    scrub_fixed  = 1'b0;
    wb_write     = 1'b0;
    ptr_adv      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!scrub_en) begin
          timer_d = '0;
        end else if (!req_valid) begin
          if (timer_q == TMR_W'(SCRUB_INTERVAL - 1)) begin
            state_d = SCRUB_RD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      SCRUB_RD: begin
        if (scrub_uncorr_raw) begin
          scrub_uncorr = 1'b1;
          ptr_adv      = 1'b1;
          state_d      = IDLE;
        end else if (scrub_corr_raw) begin
          wb_cw_d = ecc4_encode(scrub_data);
          state_d = SCRUB_WB;
        end else begin
          ptr_adv = 1'b1;
          state_d = IDLE;
        end
      end
      SCRUB_WB: begin
        wb_write    = 1'b1;
        scrub_fixed = 1'b1;
        ptr_adv     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ptr_adv) ptr_d = ptr_q + 1'b1;
  end

  // Storage next state: host write or scrub write-back, then injection XOR
  // applied on top so a fault lands even on a word written this cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (host_wr && req_addr == ADDR_W'(i)) begin
        mem_d[i] = ecc4_encode(req_wdata);
      end else if (wb_write && ptr_q == ADDR_W'(i)) begin
        mem_d[i] = wb_cw_q;
      end
      if (inj_valid && inj_addr == ADDR_W'(i)) begin
        mem_d[i] = mem_d[i] ^ inj_mask;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q         <= IDLE;
      ptr_q           <= '0;
      timer_q         <= '0;
      wb_cw_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      pass_done_q     <= 1'b0;
      corr_count_q    <= '0;
      uncorr_count_q  <= '0;
      last_err_addr_q <= '0;
    end else begin
      assert (!(host_uncorr && scrub_uncorr));
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      wb_cw_q     <= wb_cw_d;
      rsp_valid_q <= host_rd;
      rsp_err_q   <= host_uncorr;
      if (host_rd) rsp_rdata_q <= host_data;
      pass_done_q <= ptr_adv && (ptr_q == ADDR_W'(DEPTH - 1));
      if (scrub_fixed) corr_count_q <= sat_inc(corr_count_q);
      if (host_uncorr || scrub_uncorr) uncorr_count_q <= sat_inc(uncorr_count_q);
      if (scrub_uncorr) begin
        last_err_addr_q <= ptr_q;
      end else if (host_uncorr) begin
        last_err_addr_q <= req_addr;
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign scrub_busy    = (state_q != IDLE);
  assign pass_done     = pass_done_q;
  assign corr_count    = corr_count_q;
  assign uncorr_count  = uncorr_count_q;
  assign last_err_addr = last_err_addr_q;

endmodule

// File: tb/tb_ecc_scrubber_4.sv
// tb_ecc_scrubber_4: directed self-checking bench for ecc_scrubber_4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ecc_scrubber_4;
  import ecc4_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [3:0]        req_wdata = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [3:0]        rsp_rdata;
  logic              rsp_err;
  logic              scrub_en = 1'b0;
  logic              inj_valid = 1'b0;
  logic [ADDR_W-1:0] inj_addr = '0;
  logic [CW_W-1:0]   inj_mask = '0;
  logic              scrub_busy;
  logic              pass_done;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;
  logic [ADDR_W-1:0] last_err_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  ecc_scrubber_4 #(
    .DEPTH(DEPTH), .SCRUB_INTERVAL(8), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .scrub_en(scrub_en),
    .inj_valid(inj_valid), .inj_addr(inj_addr), .inj_mask(inj_mask),
    .scrub_busy(scrub_busy), .pass_done(pass_done),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .last_err_addr(last_err_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic host_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [3:0] wd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic inject(input logic [ADDR_W-1:0] addr, input logic [CW_W-1:0] mask);
    inj_valid = 1'b1; inj_addr = addr; inj_mask = mask;
    @(negedge clock);
    inj_valid = 1'b0; inj_mask = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   steps, passes, s1, s2, k;
    logic prev_busy, busy_seen;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(scrub_busy), 32'd0);
    check("rst_pass_done", 32'(pass_done), 32'd0);
    check("rst_corr", 32'(corr_count), 32'd0);
    check("rst_uncorr", 32'(uncorr_count), 32'd0);
    check("rst_last_err", 32'(last_err_addr), 32'd0);
    check("rst_mem3", 32'(dut.mem_q[3]), 32'h00);
    reset = 1'b1;
    @(negedge clock);
    check("idle_ready", 32'(req_ready), 32'd1);

    // 1: write then read back
    host_req(1'b1, 4'd3, 4'hB);
    check("t1_mem3", 32'(dut.mem_q[3]), 32'h2B);
    host_req(1'b0, 4'd3, 4'h0);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rdata", 32'(rsp_rdata), 32'hB);
    check("t1_err", 32'(rsp_err), 32'd0);
    @(negedge clock);
    check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

    // 2: single-bit fault corrected on read, no write-back
    inject(4'd3, 8'h01);
    check("t2_mem3_inj", 32'(dut.mem_q[3]), 32'h2A);
    host_req(1'b0, 4'd3, 4'h0);
    check("t2_rdata", 32'(rsp_rdata), 32'hB);
    check("t2_err", 32'(rsp_err), 32'd0);
    check("t2_corr", 32'(corr_count), 32'd0);
    check("t2_uncorr", 32'(uncorr_count), 32'd0);
    check("t2_mem3_kept", 32'(dut.mem_q[3]), 32'h2A);

    // 3: scrubber repairs the word; two full passes
    scrub_en = 1'b1;
    steps = 0; passes = 0; s1 = 0; s2 = 0; prev_busy = 1'b0;
    for (int i = 0; i < 1000 && passes < 2; i++) begin
      @(negedge clock);
      if (scrub_busy && !prev_busy) steps++;
      prev_busy = scrub_busy;
      if (pass_done) begin
        passes++;
        if (passes == 1) s1 = steps; else s2 = steps;
      end
    end
    check("t3_passes", 32'(passes), 32'd2);
    check("t3_steps_pass1", 32'(s1), 32'd16);
    check("t3_steps_pass2", 32'(s2), 32'd32);
    check("t3_corr", 32'(corr_count), 32'd1);
    check("t3_mem3", 32'(dut.mem_q[3]), 32'h2B);
    scrub_en = 1'b0;
    repeat (2) @(negedge clock);
    check("t3_idle", 32'(scrub_busy), 32'd0);

    // 4: double-bit fault on host read and on scrub
    inject(4'd3, 8'h03);
    check("t4_mem3_inj", 32'(dut.mem_q[3]), 32'h28);
    host_req(1'b0, 4'd3, 4'h0);
    check("t4_err", 32'(rsp_err), 32'd1);
    check("t4_rdata_raw", 32'(rsp_rdata), 32'h8);
    check("t4_uncorr1", 32'(uncorr_count), 32'd1);
    check("t4_last_err", 32'(last_err_addr), 32'd3);
    scrub_en = 1'b1;
    k = 0;
    while (uncorr_count != 8'd2 && k < 1000) begin
      @(negedge clock); k++;
    end
    check("t4_uncorr2", 32'(uncorr_count), 32'd2);
    check("t4_mem3_unchanged", 32'(dut.mem_q[3]), 32'h28);
    check("t4_last_err2", 32'(last_err_addr), 32'd3);
    check("t4_corr_same", 32'(corr_count), 32'd1);
    scrub_en = 1'b0;
    repeat (3) @(negedge clock);
    host_req(1'b1, 4'd3, 4'hB);

    // 5: parity-only fault repaired by scrub
    inject(4'd5, 8'h80);
    check("t5_mem5_inj", 32'(dut.mem_q[5]), 32'h80);
    host_req(1'b0, 4'd5, 4'h0);
    check("t5_rdata_pre", 32'(rsp_rdata), 32'h0);
    check("t5_err_pre", 32'(rsp_err), 32'd0);
    scrub_en = 1'b1;
    k = 0;
    while (corr_count != 8'd2 && k < 1000) begin
      @(negedge clock); k++;
    end
    check("t5_corr", 32'(corr_count), 32'd2);
    check("t5_mem5_fixed", 32'(dut.mem_q[5]), 32'h00);
    check("t5_uncorr_same", 32'(uncorr_count), 32'd2);
    scrub_en = 1'b0;
    repeat (2) @(negedge clock);
    host_req(1'b0, 4'd5, 4'h0);
    check("t5_rdata_post", 32'(rsp_rdata), 32'h0);
    check("t5_err_post", 32'(rsp_err), 32'd0);

    // 6a: continuous host traffic starves the scrubber
    scrub_en = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    busy_seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (scrub_busy) busy_seen = 1'b1;
    end
    check("t6_never_busy", 32'(busy_seen), 32'd0);
    check("t6_reads_flow", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;

    // 6b: reset during write-back discards it
    inject(4'd7, 8'h01);
    k = 0;
    while (dut.state_q != SCRUB_WB && k < 1000) begin
      @(negedge clock); k++;
    end
    check("t6_reach_wb", 32'(dut.state_q == SCRUB_WB), 32'd1);
    check("t6_wb_not_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("t6_rst_corr", 32'(corr_count), 32'd0);
    check("t6_rst_uncorr", 32'(uncorr_count), 32'd0);
    check("t6_rst_last_err", 32'(last_err_addr), 32'd0);
    check("t6_rst_busy", 32'(scrub_busy), 32'd0);
    check("t6_rst_pass_done", 32'(pass_done), 32'd0);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_rdata", 32'(rsp_rdata), 32'd0);
    check("t6_rst_mem7", 32'(dut.mem_q[7]), 32'h00);
    // injection ignored while in reset
    inject(4'd2, 8'hFF);
    check("t6_inj_in_reset", 32'(dut.mem_q[2]), 32'h00);
    scrub_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // 7: injection stacked on a same-cycle host write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 4'hB;
    inj_valid = 1'b1; inj_addr = 4'd9; inj_mask = 8'h01;
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'b0; inj_valid = 1'b0; inj_mask = '0;
    check("t7_write_inj", 32'(dut.mem_q[9]), 32'h2A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
